// File: rtl/i2c_wb_cycle_ctrl.sv
// rtl/i2c_wb_cycle_ctrl.sv - byte request to 32-bit Wishbone word access sequencer
// Handles ack/err/rty terminations, spaced retries and a strobe timeout.
module i2c_wb_cycle_ctrl #(
   parameter int DW        = 32,
   parameter int AW        = 8,
   parameter int MAX_RETRY = 3,
   parameter int RETRY_GAP = 4,
   parameter int TIMEOUT   = 255
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          req_i,
   input  logic          req_we_i,
   input  logic [AW-1:0] req_addr_i,
   input  logic [7:0]    req_data_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [1:0]    status_o,
   output logic [7:0]    rd_data_o,
   input  logic [DW-1:0] wb_data_i,
   output logic [DW-1:0] wb_data_o,
   output logic [AW-1:0] wb_addr_o,
   output logic [3:0]    wb_sel_o,
   output logic          wb_we_o,
   output logic          wb_cyc_o,
   output logic          wb_stb_o,
   input  logic          wb_ack_i,
   input  logic          wb_err_i,
   input  logic          wb_rty_i
);

   typedef enum logic [1:0] {IDLE, BUS, GAP, RESP} state_t;

   localparam logic [3:0] MAX_RETRY_C = 4'(MAX_RETRY);
   localparam logic [3:0] GAP_LAST    = 4'(RETRY_GAP - 1);
   localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [3:0]    retry_q, retry_d;
   logic [3:0]    gap_q, gap_d;
   logic [7:0]    tmo_q, tmo_d;
   logic [1:0]    lane_q, lane_d;
   logic [1:0]    status_d;
   logic [7:0]    rd_data_d;
   logic [AW-1:0] addr_d;
   logic [3:0]    sel_d;
   logic [DW-1:0] data_d;
   logic          we_d;

   always_comb begin
      state_d   = state_q;
      retry_d   = retry_q;
      gap_d     = gap_q;
      tmo_d     = tmo_q;
      lane_d    = lane_q;
      status_d  = status_o;
      rd_data_d = rd_data_o;
      addr_d    = wb_addr_o;
      sel_d     = wb_sel_o;
      data_d    = wb_data_o;
      we_d      = wb_we_o;
      case (state_q)
         IDLE: begin
            if (req_i) begin
               state_d = BUS;
               retry_d = 4'd0;
               tmo_d   = 8'd0;
               lane_d  = req_addr_i[1:0];
               addr_d  = {req_addr_i[AW-1:2], 2'b00};
               sel_d   = 4'b0001 << req_addr_i[1:0];
               data_d  = {(DW/8){req_data_i}};
               we_d    = req_we_i;
            end
         end
         BUS: begin
            // err outranks rty, which outranks ack
            if (wb_err_i) begin
               status_d = 2'b01;
               state_d  = RESP;
            end else if (wb_rty_i) begin
               if (retry_q < MAX_RETRY_C) begin
                  retry_d = retry_q + 4'd1;
                  gap_d   = 4'd0;
                  state_d = GAP;
               end else begin
                  status_d = 2'b10;
                  state_d  = RESP;
               end
            end else if (wb_ack_i) begin
               status_d = 2'b00;
               if (!wb_we_o) rd_data_d = wb_data_i[{lane_q, 3'b000} +: 8];
               state_d = RESP;
            end else if (tmo_q == TMO_LAST) begin
               status_d = 2'b11;
               state_d  = RESP;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               tmo_d   = 8'd0;
               state_d = BUS;
            end else begin
               gap_d = gap_q + 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Every output is a flop loaded from the next-state decode.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= IDLE;
         retry_q   <= 4'd0;
         gap_q     <= 4'd0;
         tmo_q     <= 8'd0;
         lane_q    <= 2'd0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         status_o  <= 2'b00;
         rd_data_o <= 8'h00;
         wb_cyc_o  <= 1'b0;
         wb_stb_o  <= 1'b0;
         wb_we_o   <= 1'b0;
         wb_sel_o  <= 4'd0;
         wb_addr_o <= '0;
         wb_data_o <= '0;
      end else begin
         state_q   <= state_d;
         retry_q   <= retry_d;
         gap_q     <= gap_d;
         tmo_q     <= tmo_d;
         lane_q    <= lane_d;
         busy_o    <= (state_d != IDLE);
         done_o    <= (state_d == RESP);
         status_o  <= status_d;
         rd_data_o <= rd_data_d;
         wb_cyc_o  <= (state_d == BUS);
         wb_stb_o  <= (state_d == BUS);
         wb_we_o   <= we_d;
         wb_sel_o  <= sel_d;
         wb_addr_o <= addr_d;
         wb_data_o <= data_d;
      end
   end

endmodule

// File: tb/tb_i2c_wb_cycle_ctrl.sv
// tb/tb_i2c_wb_cycle_ctrl.sv - scoreboard bench for i2c_wb_cycle_ctrl
// Stimulus queues expected completions; a monitor checks them at each done pulse.
module tb_i2c_wb_cycle_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        req_we = 1'b0;
   logic [7:0]  req_addr = 8'h00;
   logic [7:0]  req_data = 8'h00;
   logic        busy, done;
   logic [1:0]  status;
   logic [7:0]  rd_data;
   logic [31:0] wb_din = 32'h0;
   logic [31:0] wb_dout;
   logic [7:0]  wb_addr;
   logic [3:0]  wb_sel;
   logic        wb_we, wb_cyc, wb_stb;
   logic        ack = 1'b0, err = 1'b0, rty = 1'b0;

   i2c_wb_cycle_ctrl dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .req_i(req), .req_we_i(req_we), .req_addr_i(req_addr), .req_data_i(req_data),
      .busy_o(busy), .done_o(done), .status_o(status), .rd_data_o(rd_data),
      .wb_data_i(wb_din), .wb_data_o(wb_dout), .wb_addr_o(wb_addr), .wb_sel_o(wb_sel),
      .wb_we_o(wb_we), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
      .wb_ack_i(ack), .wb_err_i(err), .wb_rty_i(rty)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  status;
      logic [7:0]  rd;
      logic [7:0]  addr;
      logic [3:0]  sel;
      logic [31:0] data;
      logic        we;
      int          issues;
      int          stb_cycles;
      int          gap;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;

   // slave terms: 0 none, 1 ack, 2 err, 3 rty, 4 err+ack
   int slv_wait = 0;
   int slv_term[8];
   int s_issue = 0;
   int s_cnt = 0;
   bit s_prev = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (wb_stb && !s_prev) s_cnt = 0;
         if (!wb_stb && s_prev) s_issue++;
         s_prev = wb_stb;
         ack = 1'b0; err = 1'b0; rty = 1'b0;
         if (wb_stb && s_cnt == slv_wait) begin
            case (slv_term[s_issue > 7 ? 7 : s_issue])
               1: ack = 1'b1;
               2: err = 1'b1;
               3: rty = 1'b1;
               4: begin err = 1'b1; ack = 1'b1; end
               default: ;
            endcase
         end
         if (wb_stb) s_cnt++;
      end
   end

   int m_issues = 0, m_stb_cycles = 0, m_gap_run = 0, m_gap_bad = 0, m_bus_bad = 0;
   bit m_prev_stb = 1'b0, m_chk_busy = 1'b0;
   exp_t e;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            m_issues = 0; m_stb_cycles = 0; m_gap_run = 0; m_gap_bad = 0; m_bus_bad = 0;
            m_chk_busy = 1'b0;
         end else begin
            if (m_chk_busy) begin
               chk("busy_after_done", {31'd0, busy}, 32'd0);
               m_chk_busy = 1'b0;
            end
            if (wb_stb && !m_prev_stb) begin
               m_issues++;
               if (m_gap_run > 0 && exp_q.size() > 0 && m_gap_run != exp_q[0].gap) m_gap_bad++;
               m_gap_run = 0;
            end
            if (busy && !wb_cyc && !done && m_issues > 0) m_gap_run++;
            if (wb_stb) begin
               m_stb_cycles++;
               if (exp_q.size() > 0 && (wb_addr !== exp_q[0].addr || wb_sel !== exp_q[0].sel ||
                   wb_dout !== exp_q[0].data || wb_we !== exp_q[0].we || wb_cyc !== 1'b1))
                  m_bus_bad++;
            end
            if (done) begin
               if (exp_q.size() == 0) begin
                  n_cmp++; n_fail++;
                  $display("FAIL unexpected_done: got done with no pending request");
               end else begin
                  e = exp_q.pop_front();
                  chk("status", {30'd0, status}, {30'd0, e.status});
                  chk("rd_data", {24'd0, rd_data}, {24'd0, e.rd});
                  chk("issues", m_issues, e.issues);
                  chk("stb_cycles", m_stb_cycles, e.stb_cycles);
                  chk("gap_bad", m_gap_bad, 0);
                  chk("bus_fields_bad", m_bus_bad, 0);
                  chk("done_after_term", {31'd0, m_prev_stb}, 32'd1);
                  chk("cyc_in_done", {30'd0, wb_cyc, wb_stb}, 32'd0);
                  chk("busy_in_done", {31'd0, busy}, 32'd1);
               end
               m_chk_busy = 1'b1;
               m_issues = 0; m_stb_cycles = 0; m_gap_run = 0; m_gap_bad = 0; m_bus_bad = 0;
            end
         end
         m_prev_stb = wb_stb;
      end
   end

   task automatic set_slave(input int w, input int t0, input int t1, input int trest);
      slv_wait = w;
      slv_term[0] = t0;
      slv_term[1] = t1;
      for (int i = 2; i < 8; i++) slv_term[i] = trest;
      s_issue = 0;
   endtask

   task automatic push(input logic [1:0] st, input logic [7:0] rd, input logic [7:0] a,
                       input logic [3:0] sel, input logic [31:0] d, input logic we,
                       input int iss, input int sc, input int gap);
      exp_t x;
      x.status = st; x.rd = rd; x.addr = a; x.sel = sel; x.data = d; x.we = we;
      x.issues = iss; x.stb_cycles = sc; x.gap = gap;
      exp_q.push_back(x);
   endtask

   task automatic issue(input logic we, input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      req = 1'b1; req_we = we; req_addr = a; req_data = d;
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic wait_done(input bit stray);
      bit got = 1'b0;
      int n = 0;
      while (!got && n < 2000) begin
         @(negedge clk);
         n++;
         if (done) got = 1'b1;
      end
      if (!got) begin
         n_cmp++; n_fail++;
         $display("FAIL done_timeout: got no done within 2000 cycles");
      end else if (stray) begin
         req = 1'b1; req_we = 1'b1; req_addr = 8'h44; req_data = 8'hEE;
         @(negedge clk);
         req = 1'b0;
      end
   endtask

   initial begin
      set_slave(0, 1, 1, 1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_status", {30'd0, status}, 0);
      chk("rst_rd", {24'd0, rd_data}, 0);
      chk("rst_cyc_stb_we", {29'd0, wb_cyc, wb_stb, wb_we}, 0);
      chk("rst_sel_addr", {20'd0, wb_sel, wb_addr}, 0);
      chk("rst_dout", wb_dout, 0);

      // write lane 2, zero-wait ack
      set_slave(0, 1, 1, 1);
      push(2'b00, 8'h00, 8'h04, 4'b0100, 32'hA5A5A5A5, 1'b1, 1, 1, 0);
      issue(1'b1, 8'h06, 8'hA5);
      wait_done(1'b0);

      // read lane 3 with three wait states
      set_slave(3, 1, 1, 1);
      wb_din = 32'h11223344;
      push(2'b00, 8'h11, 8'h08, 4'b1000, 32'h0, 1'b0, 1, 4, 0);
      issue(1'b0, 8'h0B, 8'h00);
      wait_done(1'b0);

      // rty, rty, ack on lane 1
      set_slave(0, 3, 3, 1);
      push(2'b00, 8'h33, 8'h00, 4'b0010, 32'h0, 1'b0, 3, 3, 4);
      issue(1'b0, 8'h01, 8'h00);
      wait_done(1'b0);

      // rty forever: four issues then retries exhausted
      set_slave(0, 3, 3, 3);
      push(2'b10, 8'h33, 8'h00, 4'b0100, 32'h3C3C3C3C, 1'b1, 4, 4, 4);
      issue(1'b1, 8'h02, 8'h3C);
      wait_done(1'b0);

      // silent slave: timeout after 255 strobe cycles
      set_slave(0, 0, 0, 0);
      push(2'b11, 8'h33, 8'h00, 4'b1000, 32'h0, 1'b0, 1, 255, 0);
      issue(1'b0, 8'h03, 8'h00);
      wait_done(1'b0);

      // err+ack together; stray requests during busy and in the done cycle
      set_slave(2, 4, 4, 4);
      push(2'b01, 8'h33, 8'h10, 4'b0001, 32'h0, 1'b0, 1, 3, 0);
      issue(1'b0, 8'h10, 8'h00);
      req = 1'b1; req_we = 1'b1; req_addr = 8'h21; req_data = 8'h77;
      @(negedge clk);
      req = 1'b0;
      wait_done(1'b1);
      repeat (8) @(negedge clk);
      chk("stray_busy", {31'd0, busy}, 0);
      chk("stray_cyc", {31'd0, wb_cyc}, 0);

      // reset in the middle of a bus cycle
      set_slave(0, 0, 0, 0);
      issue(1'b0, 8'h20, 8'h00);
      repeat (3) @(negedge clk);
      chk("pre_rst_stb", {31'd0, wb_stb}, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_cyc_stb", {30'd0, wb_cyc, wb_stb}, 0);
      chk("mid_rst_busy_done", {30'd0, busy, done}, 0);
      chk("mid_rst_status", {30'd0, status}, 0);
      chk("mid_rst_rd", {24'd0, rd_data}, 0);
      begin
         int seen = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || wb_cyc) seen++;
         end
         chk("post_rst_quiet", seen, 0);
      end

      // back-to-back: second request in the first idle cycle after done
      set_slave(0, 1, 1, 1);
      wb_din = 32'hAABBCCDD;
      push(2'b00, 8'h00, 8'h04, 4'b0010, 32'h5A5A5A5A, 1'b1, 1, 1, 0);
      push(2'b00, 8'hBB, 8'h0C, 4'b0100, 32'h0, 1'b0, 1, 1, 0);
      issue(1'b1, 8'h05, 8'h5A);
      wait_done(1'b0);
      issue(1'b0, 8'h0E, 8'h00);
      wait_done(1'b0);
      repeat (3) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
